// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXE_R   = 4'd6,
    S_EXE_I   = 4'd7,
    S_ALUWB_R = 4'd8,
    S_ALUWB_I = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU = 4'd0,
    C_SUBU = 4'd1,
    C_ORI  = 4'd2,
    C_LUI  = 4'd3,
    C_LW   = 4'd4,
    C_SW   = 4'd5,
    C_BEQ  = 4'd6,
    C_J    = 4'd7,
    C_NONE = 4'd8
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0011;

  localparam logic [1:0] SRCB_BUSB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct from the IR to a class and a legal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       legal
);

  // Map opcode (and funct for R-type) onto the supported instruction classes.
  always_comb begin
    iclass = C_NONE;
    legal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU) begin
          iclass = C_ADDU;
          legal  = 1'b1;
        end else if (funct == FN_SUBU) begin
          iclass = C_SUBU;
          legal  = 1'b1;
        end
      end
      OP_ORI: begin iclass = C_ORI; legal = 1'b1; end
      OP_LUI: begin iclass = C_LUI; legal = 1'b1; end
      OP_LW:  begin iclass = C_LW;  legal = 1'b1; end
      OP_SW:  begin iclass = C_SW;  legal = 1'b1; end
      OP_BEQ: begin iclass = C_BEQ; legal = 1'b1; end
      OP_J:   begin iclass = C_J;   legal = 1'b1; end
      default: begin
        iclass = C_NONE;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: sequences the MIPS datapath over shared-memory cycles
// and counts retired instructions.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | read instruction at PC, PC+4 -> PC and IR load on mem_ready
// DECODE    | classify IR, branch target -> ALUOut
// MEMADR    | base + sign-extended offset -> ALUOut
// MEMRD     | load data read at ALUOut, wait for mem_ready
// MEMWB     | MDR -> rt
// MEMWR     | store busB at ALUOut, wait for mem_ready
// EXE_R     | busA op busB (addu/subu)
// EXE_I     | busA op zero-extended imm (ori/lui)
// ALUWB_R   | ALUOut -> rd
// ALUWB_I   | ALUOut -> rt
// BRANCH    | compare busA/busB, conditional PC write from ALUOut
// JUMP      | PC <- jump target
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic             pc_wr_cond,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             ext_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctr,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t           state_q;
  state_t           state_d;
  iclass_t          iclass;
  logic             legal;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_q;

  // The beq decision is taken in the datapath (pc_wr_cond & zero), so the
  // controller only carries the flag through.
  logic unused_zero;
  assign unused_zero = zero;

  mc_decode u_decode (
    .op     (op),
    .funct  (funct),
    .iclass (iclass),
    .legal  (legal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)        cnt_q <= '0;
    else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Count is forced to zero while reset is held so nothing stale is visible.
  assign instr_cnt = reset ? '0 : cnt_q;

  // Next-state and per-state output decode; reset masks every output.
  always_comb begin
    state_d    = state_q;
    cnt_inc    = 1'b0;
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_BUSB;
    alu_ctr    = ALU_ADD;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        ext_op    = 1'b1;
        if (!legal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          case (iclass)
            C_LW, C_SW:     state_d = S_MEMADR;
            C_ADDU, C_SUBU: state_d = S_EXE_R;
            C_ORI, C_LUI:   state_d = S_EXE_I;
            C_BEQ:          state_d = S_BRANCH;
            C_J:            state_d = S_JUMP;
            default:        state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
        state_d   = (iclass == C_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        cnt_inc    = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ready) begin
          cnt_inc = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXE_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_BUSB;
        alu_ctr   = (iclass == C_SUBU) ? ALU_SUB : ALU_ADD;
        state_d   = S_ALUWB_R;
      end
      S_EXE_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctr   = (iclass == C_LUI) ? ALU_LUI : ALU_OR;
        state_d   = S_ALUWB_I;
      end
      S_ALUWB_R: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        cnt_inc = 1'b1;
        state_d = S_FETCH;
      end
      S_ALUWB_I: begin
        reg_wr  = 1'b1;
        cnt_inc = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_BUSB;
        alu_ctr    = ALU_SUB;
        pc_wr_cond = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        cnt_inc    = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_wr   = 1'b1;
        pc_src  = PCSRC_JUMP;
        cnt_inc = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      pc_wr      = 1'b0;
      pc_wr_cond = 1'b0;
      pc_src     = PCSRC_ALU;
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      ext_op     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_BUSB;
      alu_ctr    = ALU_ADD;
      illegal    = 1'b0;
      cnt_inc    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expectations (length, enable
// counts, key-cycle selects, retired count) derived from instruction class and
// memory wait counts.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero, mem_ready;
  logic        pc_wr, pc_wr_cond, iord, mem_rd, mem_wr, ir_wr, reg_wr;
  logic        reg_dst, mem_to_reg, ext_op, alu_src_a, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_ctr;
  logic [31:0] instr_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_cnt;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond),
    .pc_src(pc_src), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_wr(ir_wr), .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .ext_op(ext_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctr(alu_ctr), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] all_outs();
    return {pc_wr, pc_wr_cond, pc_src, iord, mem_rd, mem_wr, ir_wr, reg_wr,
            reg_dst, mem_to_reg, ext_op, alu_src_a, alu_src_b, alu_ctr, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:   return (f == 6'h21 || f == 6'h23) ? K_R : K_ILL;
      6'h0D, 6'h0F: return K_I;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] exe_alu(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) return (f == 6'h23) ? 4'b0001 : 4'b0000;
    if (o == 6'h0D) return 4'b0010;
    if (o == 6'h0F) return 4'b0011;
    return 4'b0000;
  endfunction

  // One instruction starting in FETCH; wf fetch waits, wm memory waits.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
    int k, len, mstart, body;
    int n_rd, n_wr, n_ir, n_pc, n_pcc, n_rw, n_iord, n_ill, n_a, n_ext;
    logic [1:0] fb, db, xb, lpc;
    logic [3:0] dctr, xctr, lctr;
    logic fpw, fiord, dext, xext, ldst, lm2r;
    logic [31:0] cnt_last;
    bit is_mem;
    k = kind_of(o, f);
    is_mem = (k == K_LW) || (k == K_SW);
    case (k)
      K_R, K_I:   body = 3;
      K_LW:       body = 4 + wm;
      K_SW:       body = 3 + wm;
      K_BEQ, K_J: body = 2;
      default:    body = 1;
    endcase
    len = wf + 1 + body;
    mstart = wf + 3;
    {n_rd, n_wr, n_ir, n_pc, n_pcc, n_rw, n_iord, n_ill, n_a, n_ext} = '0;
    {fb, db, xb, lpc, dctr, xctr, lctr, fpw, fiord, dext, xext, ldst, lm2r} = '0;
    cnt_last = '0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      reset = 1'b0;
      op = o;
      funct = f;
      zero = 1'($urandom);
      if (c < wf)                              mem_ready = 1'b0;
      else if (c == wf)                        mem_ready = 1'b1;
      else if (is_mem && c >= mstart && c < mstart + wm) mem_ready = 1'b0;
      else if (is_mem && c == mstart + wm)     mem_ready = 1'b1;
      else                                     mem_ready = 1'($urandom);
      #1;
      n_rd += int'(mem_rd); n_wr += int'(mem_wr); n_ir += int'(ir_wr);
      n_pc += int'(pc_wr); n_pcc += int'(pc_wr_cond); n_rw += int'(reg_wr);
      n_iord += int'(iord); n_ill += int'(illegal); n_a += int'(alu_src_a);
      n_ext += int'(ext_op);
      if (c == wf)     begin fb = alu_src_b; fpw = pc_wr & ir_wr; fiord = iord; end
      if (c == wf + 1) begin db = alu_src_b; dctr = alu_ctr; dext = ext_op; end
      if (c == wf + 2) begin xb = alu_src_b; xctr = alu_ctr; xext = ext_op; end
      if (c == len - 1) begin
        ldst = reg_dst; lm2r = mem_to_reg; lpc = pc_src; lctr = alu_ctr;
        cnt_last = instr_cnt;
      end
    end
    check("mem_rd_cycles", n_rd, wf + 1 + ((k == K_LW) ? wm + 1 : 0));
    check("mem_wr_cycles", n_wr, (k == K_SW) ? wm + 1 : 0);
    check("iord_cycles",   n_iord, is_mem ? wm + 1 : 0);
    check("ir_wr_cycles",  n_ir, 1);
    check("pc_wr_cycles",  n_pc, (k == K_J) ? 2 : 1);
    check("pc_wr_cond_cycles", n_pcc, (k == K_BEQ) ? 1 : 0);
    check("reg_wr_cycles", n_rw, (k == K_R || k == K_I || k == K_LW) ? 1 : 0);
    check("illegal_cycles", n_ill, (k == K_ILL) ? 1 : 0);
    check("alu_src_a_cycles", n_a, (k == K_J || k == K_ILL) ? 0 : 1);
    check("ext_op_cycles", n_ext, is_mem ? 2 : 1);
    check("fetch_pcwr_irwr", 32'(fpw), 1);
    check("fetch_srcb", 32'(fb), 32'h1);
    check("fetch_iord", 32'(fiord), 0);
    check("decode_srcb", 32'(db), 32'h3);
    check("decode_alu", 32'(dctr), 0);
    check("decode_ext", 32'(dext), 1);
    if (k == K_R || k == K_I || is_mem) begin
      check("exe_alu", 32'(xctr), is_mem ? 0 : 32'(exe_alu(o, f)));
      check("exe_srcb", 32'(xb), (k == K_R) ? 0 : 32'h2);
      check("exe_ext", 32'(xext), is_mem ? 1 : 0);
    end
    check("last_reg_dst", 32'(ldst), (k == K_R) ? 1 : 0);
    check("last_mem_to_reg", 32'(lm2r), (k == K_LW) ? 1 : 0);
    check("last_pc_src", 32'(lpc), (k == K_BEQ) ? 1 : (k == K_J) ? 2 : 0);
    check("last_alu", 32'(lctr), (k == K_BEQ) ? 1 : 0);
    check("cnt_before_retire", cnt_last, exp_cnt);
    if (k != K_ILL) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
    check("instr_cnt", instr_cnt, exp_cnt);
  endtask

  logic [5:0] tbl_op [10] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h00};
  logic [5:0] tbl_fn [10] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20};

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    exp_cnt = '0;

    // Reset held two cycles: everything quiet.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("reset_outputs", 32'(all_outs()), 0);
      check("reset_cnt", instr_cnt, 0);
    end

    // Directed sequence.
    run_instr(6'h00, 6'h21, 0, 0);   // addu
    run_instr(6'h0D, 6'h00, 0, 0);   // ori
    run_instr(6'h23, 6'h00, 0, 3);   // lw, 3 waits in MEMRD
    run_instr(6'h2B, 6'h00, 0, 2);   // sw, 2 waits in MEMWR
    run_instr(6'h04, 6'h00, 0, 0);   // beq
    run_instr(6'h02, 6'h00, 0, 0);   // j
    run_instr(6'h3F, 6'h00, 0, 0);   // illegal op
    run_instr(6'h00, 6'h20, 0, 0);   // illegal funct
    run_instr(6'h0F, 6'h00, 2, 0);   // lui with fetch waits
    run_instr(6'h00, 6'h23, 1, 0);   // subu

    // Reset during a MEMWR wait.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      op = 6'h2B; funct = 6'h00;
      mem_ready = (c == 0) ? 1'b1 : (c == 3 || c == 4) ? 1'b0 : 1'($urandom);
      reset = (c == 4);
      #1;
      if (c == 3) check("memwr_wait_mem_wr", 32'(mem_wr), 1);
      if (c == 4) begin
        check("reset_in_wait_outputs", 32'(all_outs()), 0);
        check("reset_in_wait_cnt", instr_cnt, 0);
      end
    end
    exp_cnt = '0;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    check("post_reset_mem_rd", 32'(mem_rd), 1);
    check("post_reset_mem_wr", 32'(mem_wr), 0);
    check("post_reset_cnt", instr_cnt, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      int idx;
      idx = int'($urandom_range(0, 9));
      run_instr(tbl_op[idx], tbl_fn[idx], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
